// File: rtl/output_scanout.sv
// output_scanout: raster timing generator and frame RAM scanout stage.
// Counters and read_address update on the same edge, so the address for pixel (h,v)
// is on the RAM port while the counters sit at (h,v). The RAM returns data one clock
// later, and the rgb register adds one more clock. Pixel (h,v) therefore appears on rgb
// 2 clocks after the counters reach (h,v). de/hsync/vsync go through a matching
// 2-deep delay.
module output_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 22,
  parameter int PIX_W    = 24
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              enable,
  input  logic              buf_sel,
  input  logic [PIX_W-1:0]  ram_q,
  output logic [ADDR_W-1:0] read_address,
  output logic [PIX_W-1:0]  rgb,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_ONE  = HW'(1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_ONE  = VW'(1);

  // Second framebuffer starts right after the first one.
  localparam logic [ADDR_W-1:0] BUF1_BASE = ADDR_W'(H_ACTIVE * V_ACTIVE);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_q;
  logic [HW-1:0]       h_q;
  logic [VW-1:0]       v_q;
  logic [ADDR_W-1:0]   read_address_q;
  logic                frame_start_q;

  // Two-deep delay line for the timing signals, plus the aligned rgb register.
  logic                de_p_q, hs_p_q, vs_p_q;
  logic                de_q, hsync_q, vsync_q;
  logic [PIX_W-1:0]    rgb_q;

  logic                running_s;
  logic                act_s;
  logic                hs_s;
  logic                vs_s;
  logic [HW-1:0]       h_nx_s;
  logic [VW-1:0]       v_nx_s;
  logic [ADDR_W-1:0]   base_s;

  // Decode of the current counter position (stage 0).
  assign running_s = (state_q == ST_RUN);
  assign act_s     = running_s && (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_s      = !(running_s && (h_q >= HS_BEG) && (h_q < HS_END));
  assign vs_s      = !(running_s && (v_q >= VS_BEG) && (v_q < VS_END));
  assign h_nx_s    = h_q + H_ONE;
  assign v_nx_s    = v_q + V_ONE;
  assign base_s    = buf_sel ? BUF1_BASE : '0;

  // Run/idle FSM with raster counters, read address and frame_start.
  // The address is loaded with the base at a frame start. It advances only when the
  // next position is active, so it holds through blanking.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= ST_IDLE;
      h_q            <= '0;
      v_q            <= '0;
      read_address_q <= '0;
      frame_start_q  <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          h_q <= '0;
          v_q <= '0;
          if (enable) begin
            state_q        <= ST_RUN;
            frame_start_q  <= 1'b1;
            read_address_q <= base_s;
          end else begin
            state_q        <= ST_IDLE;
            read_address_q <= '0;
          end
        end
        ST_RUN: begin
          if (h_q == H_LAST) begin
            h_q <= '0;
            if (v_q == V_LAST) begin
              v_q <= '0;
              if (enable) begin
                frame_start_q  <= 1'b1;
                read_address_q <= base_s;
              end else begin
                state_q        <= ST_IDLE;
                read_address_q <= '0;
              end
            end else begin
              v_q <= v_nx_s;
              if (v_nx_s < V_ACT) begin
                read_address_q <= read_address_q + ADDR_ONE;
              end else begin
                read_address_q <= read_address_q;
              end
            end
          end else begin
            h_q <= h_nx_s;
            if ((h_nx_s < H_ACT) && (v_q < V_ACT)) begin
              read_address_q <= read_address_q + ADDR_ONE;
            end else begin
              read_address_q <= read_address_q;
            end
          end
        end
        default: begin
          state_q        <= ST_IDLE;
          h_q            <= '0;
          v_q            <= '0;
          read_address_q <= '0;
        end
      endcase
    end
  end

  // Delay the timing signals 2 clocks and register the RAM data, blanked outside de.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      de_p_q  <= 1'b0;
      hs_p_q  <= 1'b1;
      vs_p_q  <= 1'b1;
      de_q    <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= '0;
    end else begin
      de_p_q  <= act_s;
      hs_p_q  <= hs_s;
      vs_p_q  <= vs_s;
      de_q    <= de_p_q;
      hsync_q <= hs_p_q;
      vsync_q <= vs_p_q;
      rgb_q   <= de_p_q ? ram_q : '0;
    end
  end

  assign read_address = read_address_q;
  assign frame_start  = frame_start_q;
  assign de           = de_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign rgb          = rgb_q;

endmodule

// File: tb/tb_output_scanout.sv
// Randomized bench for output_scanout using a small raster geometry.
// The reference model tracks a frame-relative clock index k, and whether scanout runs.
// From k and the base it derives every expected output arithmetically.
module tb_output_scanout;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int AW = 22;
  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          enable = 1'b0;
  logic          buf_sel = 1'b0;
  logic [PW-1:0] ram_q = '0;
  logic [AW-1:0] read_address;
  logic [PW-1:0] rgb;
  logic          de, hsync, vsync, frame_start;

  output_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .ADDR_W(AW), .PIX_W(PW)
  ) dut (
    .clk(clk), .n_rst(n_rst), .enable(enable), .buf_sel(buf_sel), .ram_q(ram_q),
    .read_address(read_address), .rgb(rgb), .de(de), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // RAM contents: a scrambled function of the address, so swapped or stale reads show up.
  function automatic logic [PW-1:0] pix_of(input logic [AW-1:0] a);
    logic [PW-1:0] t;
    t = PW'(a);
    return t ^ 24'hC35A00;
  endfunction

  // RAM with one clock of read latency.
  always @(posedge clk) ram_q <= pix_of(read_address);

  typedef struct packed {
    logic          de;
    logic          hs;
    logic          vs;
    logic          fs;
    logic [AW-1:0] addr;
  } raw_t;

  // Expected undelayed values at frame clock k.
  // addr = base + (pixels issued so far in this frame) - 1.
  function automatic raw_t raw_of(input bit run, input int k, input int base);
    raw_t r;
    int h, v, issued;
    r.de = 1'b0; r.hs = 1'b1; r.vs = 1'b1; r.fs = 1'b0; r.addr = '0;
    if (run) begin
      h = k % HT;
      v = k / HT;
      r.de = (h < HA) && (v < VA);
      r.hs = !((h >= HA + HF) && (h < HA + HF + HS));
      r.vs = !((v >= VA + VF) && (v < VA + VF + VS));
      r.fs = (k == 0);
      issued = (v < VA) ? (v * HA + ((h < HA) ? h + 1 : HA)) : HA * VA;
      r.addr = AW'(base + issued - 1);
    end
    return r;
  endfunction

  bit   m_run;
  int   m_k;
  int   m_base;
  raw_t d1, d2, blank;
  int   vectors;
  int   miscompares;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_step();
    if (!n_rst) begin
      m_run = 1'b0; m_k = 0; d1 = blank; d2 = blank;
    end else begin
      d2 = d1;
      d1 = raw_of(m_run, m_k, m_base);
      if (!m_run) begin
        if (enable) begin
          m_run = 1'b1; m_k = 0; m_base = buf_sel ? HA * VA : 0;
        end
      end else if (m_k == FT - 1) begin
        m_k = 0;
        if (enable) m_base = buf_sel ? HA * VA : 0;
        else m_run = 1'b0;
      end else begin
        m_k++;
      end
    end
  endtask

  task automatic compare_all();
    raw_t cur;
    cur = raw_of(m_run, m_k, m_base);
    chk("read_address", 32'(read_address), 32'(cur.addr));
    chk("frame_start", 32'(frame_start), 32'(cur.fs));
    chk("de", 32'(de), 32'(d2.de));
    chk("hsync", 32'(hsync), 32'(d2.hs));
    chk("vsync", 32'(vsync), 32'(d2.vs));
    chk("rgb", 32'(rgb), d2.de ? 32'(pix_of(d2.addr)) : 32'd0);
  endtask

  // mode 0: enable low, 1: enable high, 2: random enable (mostly high)
  task automatic run_cycles(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compare_all();
      enable  = (mode == 1) ? 1'b1 : (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b0;
      buf_sel = 1'($urandom_range(0, 1));
      @(posedge clk);
      model_step();
    end
  endtask

  // Reset asserted between edges; the outputs must clear without waiting for a clock.
  task automatic async_reset(input int mode);
    @(negedge clk);
    compare_all();
    #2 n_rst = 1'b0;
    #1;
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_de", 32'(de), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_read_address", 32'(read_address), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    @(posedge clk);
    model_step();
    run_cycles(2, mode);
    #1 n_rst = 1'b1;
  endtask

  initial begin
    raw_t r;
    int   guard;
    vectors = 0; miscompares = 0;
    m_run = 1'b0; m_k = 0; m_base = 0;
    blank = raw_of(1'b0, 0, 0);
    d1 = blank; d2 = blank;

    // Hand-computed points that pin the model's arithmetic.
    r = raw_of(1'b1, 9, 0);
    chk("pin_addr_v1h1", 32'(r.addr), 32'd5);
    r = raw_of(1'b1, 12, 0);
    chk("pin_hold_addr", 32'(r.addr), 32'd7);
    chk("pin_blank_de", 32'(r.de), 32'd0);
    r = raw_of(1'b1, 20, HA * VA);
    chk("pin_buf1_last", 32'(r.addr), 32'd23);
    r = raw_of(1'b1, 37, 0);
    chk("pin_vsync_line", 32'(r.vs), 32'd0);
    chk("pin_hsync_h5", 32'(r.hs), 32'd0);

    // Reset held, then released while idle.
    run_cycles(3, 0);
    #1 n_rst = 1'b1;
    run_cycles(4, 0);

    // Continuous frames, then random enable drops, then drain to idle.
    run_cycles(150, 1);
    run_cycles(500, 2);
    run_cycles(60, 0);

    // Restart, reset at v=2 h=1, resume with enable held.
    guard = 0;
    while (!(m_run && m_k == 2 * HT + 1) && guard < 200) begin
      run_cycles(1, 1);
      guard++;
    end
    chk("reach_v2h1_timeout", 32'(guard < 200), 32'd1);
    async_reset(1);
    run_cycles(100, 1);

    run_cycles(300, 2);
    async_reset(2);
    run_cycles(200, 2);
    run_cycles(60, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
